instr_fetch_seq: RTL

//   Instruction fetch sequencer feeding the opcode/funct inputs of control_32. Owns the PC.

---
 rtl/instr_fetch_seq.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/instr_fetch_seq.sv
// instr_fetch_seq: instruction fetch sequencer that owns the PC.
// Fetches words over a req/ack handshake and holds each one on a valid/ready
// interface toward control_32. When an instruction is accepted, the next PC
// is resolved from that instruction's branch/jump/zero/rs_data. The sequencer
// halts on an illegal opcode or on a reserved control encoding.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When it is defined, a
// misaligned next PC or a misaligned RESET_PC halts the sequencer and sets
// err_misalign.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_RST   | leaving reset, no request issued, any late imem_ack ignored
// ST_FETCH | imem_req high at pc, waiting for imem_ack
// ST_ISSUE | instr_valid high, waiting for instr_ready to resolve next pc
// ST_HALT  | stopped on error, all strobes low, only rst_n recovers

`timescale 1ns/1ps

module instr_fetch_seq #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic [1:0]        branch,
    input  logic [1:0]        jump,
    input  logic              zero,
    input  logic [ADDR_W-1:0] rs_data,
    input  logic              ctrl_err,
    output logic              halted,
    output logic              err_misalign
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_ISSUE = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic [31:0]       r_instr;
    logic [31:0]       w_instr_nxt;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_jump_tgt;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_target;
    logic              w_taken;
    logic              w_fatal;

`ifdef FETCH_ALIGN_CHECK_EN
    logic              r_err_misalign;
    logic              w_misalign_set;
`endif

    // Sequential-address and branch/jump target arithmetic, all modulo 2^ADDR_W
    assign w_pc_plus4   = r_pc + ADDR_W'(4);
    assign w_jump_tgt   = {w_pc_plus4[ADDR_W-1:ADDR_W-4], r_instr[25:0], 2'b00};
    assign w_branch_tgt = w_pc_plus4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};

    // Reserved encodings are treated like an illegal opcode
    assign w_fatal = ctrl_err || (jump == 2'b11) || (branch == 2'b11);
    assign w_taken = ((branch == 2'b01) && zero) || ((branch == 2'b10) && !zero);

    // Next-PC priority: jump, then jr, then taken branch, then fall-through
    always_comb begin
        w_target = w_pc_plus4;
        if (jump == 2'b01) begin
            w_target = w_jump_tgt;
        end else if (jump == 2'b10) begin
            w_target = rs_data;
        end else if (w_taken) begin
            w_target = w_branch_tgt;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and the handshake strobes
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_instr_nxt = r_instr;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        halted      = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
        w_misalign_set = 1'b0;
`endif
        case (r_state)
            ST_RST: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (RESET_PC[1:0] != 2'b00) begin
                    w_state_nxt    = ST_HALT;
                    w_misalign_set = 1'b1;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
`else
                w_state_nxt = ST_FETCH;
`endif
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    w_instr_nxt = imem_rdata;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    if (w_fatal) begin
                        w_state_nxt = ST_HALT;
`ifdef FETCH_ALIGN_CHECK_EN
                    end else if (w_target[1:0] != 2'b00) begin
                        w_state_nxt    = ST_HALT;
                        w_misalign_set = 1'b1;
`endif
                    end else begin
                        w_pc_nxt    = w_target;
                        w_state_nxt = ST_FETCH;
                    end
                end
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = ST_RST;
            end
        endcase
    end

    // PC and instruction registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= RESET_PC[ADDR_W-1:0];
            r_instr <= 32'h0000_0000;
        end else begin
            r_pc    <= w_pc_nxt;
            r_instr <= w_instr_nxt;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    // Sticky misalignment flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_misalign <= 1'b0;
        end else if (w_misalign_set) begin
            r_err_misalign <= 1'b1;
        end
    end

    assign err_misalign = r_err_misalign;
`else
    assign err_misalign = 1'b0;
`endif

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign pc_plus4  = w_pc_plus4;
    assign instr     = r_instr;
    assign opcode    = r_instr[31:26];
    assign funct     = r_instr[5:0];

endmodule
